// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel-in / 3x3-window-out stream bundle for sobel_window_gen
interface sobel_window_gen_if #(
    parameter int WIDTH  = 549,
    parameter int HEIGHT = 319,
    parameter int DW     = 8
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    logic [DW-1:0]    in_pix;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    P00, P01, P02, P10, P11, P12, P20, P21, P22;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             win_last;
    modport master (
        output in_pix, in_valid, out_ready,
        input  in_ready, P00, P01, P02, P10, P11, P12, P20, P21, P22,
               out_valid, win_row, win_col, win_last
    );
    modport slave (
        input  in_pix, in_valid, out_ready,
        output in_ready, P00, P01, P02, P10, P11, P12, P20, P21, P22,
               out_valid, win_row, win_col, win_last
    );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixel stream to 3x3 interior windows via two line buffers and a shift array
module sobel_window_gen #(
    parameter int WIDTH  = 549,
    parameter int HEIGHT = 319,
    parameter int DW     = 8,
    parameter int COL_W  = $clog2(WIDTH),
    parameter int ROW_W  = $clog2(HEIGHT)
) (
    input logic               clk,
    input logic               rst_n,
    sobel_window_gen_if.slave bus
);
    logic [DW-1:0]    lb0_q [WIDTH];
    logic [DW-1:0]    lb1_q [WIDTH];
    logic [DW-1:0]    sh_q [3][3];
    logic [DW-1:0]    sh_d [3][3];
    logic [DW-1:0]    new_col [3];
    logic [COL_W-1:0] col_q, col_d, win_col_q, win_col_d;
    logic [ROW_W-1:0] row_q, row_d, win_row_q, win_row_d;
    logic             vld_q, vld_d, last_q, last_d;
    logic             acc, col_end, row_end, emit;

    assign bus.in_ready = !vld_q || bus.out_ready;
    assign acc          = bus.in_valid && bus.in_ready;
    assign col_end      = col_q == COL_W'(WIDTH - 1);
    assign row_end      = row_q == ROW_W'(HEIGHT - 1);

    // Next state: everything moves only on an accept; a window is emitted for interior centres
    always_comb begin
        emit       = acc && row_q >= ROW_W'(2) && col_q >= COL_W'(2);
        col_d      = acc ? (col_end ? '0 : col_q + COL_W'(1)) : col_q;
        row_d      = (acc && col_end) ? (row_end ? '0 : row_q + ROW_W'(1)) : row_q;
        vld_d      = acc ? emit : vld_q && !bus.out_ready;
        last_d     = vld_d && (acc ? col_end && row_end : last_q);
        win_row_d  = emit ? row_q - ROW_W'(1) : win_row_q;
        win_col_d  = emit ? col_q - COL_W'(1) : win_col_q;
        new_col[0] = lb1_q[col_q];
        new_col[1] = lb0_q[col_q];
        new_col[2] = bus.in_pix;
        for (int r = 0; r < 3; r++) begin
            sh_d[r][0] = acc ? sh_q[r][1] : sh_q[r][0];
            sh_d[r][1] = acc ? sh_q[r][2] : sh_q[r][1];
            sh_d[r][2] = acc ? new_col[r] : sh_q[r][2];
        end
    end

    // State register: counters, shift array (doubles as the window) and output tags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
            sh_q      <= '{default: '0};
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            sh_q      <= sh_d;
        end
    end

    // Line buffers: the pixel above moves down to lb1 as the new pixel lands in lb0
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= bus.in_pix;
        end
    end

    assign bus.P00       = sh_q[0][0];
    assign bus.P01       = sh_q[0][1];
    assign bus.P02       = sh_q[0][2];
    assign bus.P10       = sh_q[1][0];
    assign bus.P11       = sh_q[1][1];
    assign bus.P12       = sh_q[1][2];
    assign bus.P20       = sh_q[2][0];
    assign bus.P21       = sh_q[2][1];
    assign bus.P22       = sh_q[2][2];
    assign bus.out_valid = vld_q;
    assign bus.win_last  = last_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed 5x4 scenarios plus randomized 12x7 frames against a 3x3 extraction model
module tb_sobel_window_gen;
    localparam int AW = 5, AH = 4, BW = 12, BH = 7, BF = 3;
    typedef logic [88:0] win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_window_gen_if #(.WIDTH(AW), .HEIGHT(AH), .DW(8)) a ();
    sobel_window_gen_if #(.WIDTH(BW), .HEIGHT(BH), .DW(8)) b ();
    sobel_window_gen #(.WIDTH(AW), .HEIGHT(AH), .DW(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    sobel_window_gen #(.WIDTH(BW), .HEIGHT(BH), .DW(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    int n_cmp = 0, n_bad = 0;
    int na_win = 0, na_last = 0, nb_win = 0, nb_last = 0;
    win_t qa[$], qb[$];
    win_t obs_a, obs_b, ea, eb;
    logic [7:0] img_a [AH][AW];
    logic [7:0] img_b [BF][BH][BW];

    assign obs_a = {a.P00, a.P01, a.P02, a.P10, a.P11, a.P12, a.P20, a.P21, a.P22,
                    8'(a.win_row), 8'(a.win_col), a.win_last};
    assign obs_b = {b.P00, b.P01, b.P02, b.P10, b.P11, b.P12, b.P20, b.P21, b.P22,
                    8'(b.win_row), 8'(b.win_col), b.win_last};

    // Scoreboards: every transferred window must be the next one of the golden raster-order list
    always @(negedge clk) begin
        if (a.out_valid && a.out_ready) begin
            na_win++;
            if (a.win_last) na_last++;
            ea = (qa.size() != 0) ? qa.pop_front() : '1;
            n_cmp++;
            assert (obs_a === ea) else begin
                n_bad++;
                $error("FAIL win_a observed=%h expected=%h", obs_a, ea);
            end
        end
    end

    always @(negedge clk) begin
        if (b.out_valid && b.out_ready) begin
            nb_win++;
            if (b.win_last) nb_last++;
            eb = (qb.size() != 0) ? qb.pop_front() : '1;
            n_cmp++;
            assert (obs_b === eb) else begin
                n_bad++;
                $error("FAIL win_b observed=%h expected=%h", obs_b, eb);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_a(input logic [7:0] base, input bit rnd);
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++)
                img_a[r][c] = rnd ? 8'($urandom) : (base | 8'(r << 4) | 8'(c));
    endtask

    // Golden extraction: first n interior windows of img_a in raster order
    task automatic push_a(input int n);
        int k = 0;
        logic [71:0] px;
        for (int r = 1; r < AH - 1; r++)
            for (int c = 1; c < AW - 1; c++) begin
                px = '0;
                for (int i = 0; i < 9; i++) px = {px[63:0], img_a[r - 1 + i / 3][c - 1 + i % 3]};
                if (k < n) qa.push_back({px, 8'(r), 8'(c), 1'(r == AH - 2 && c == AW - 2)});
                k++;
            end
    endtask

    task automatic push_b(input int f);
        logic [71:0] px;
        for (int r = 1; r < BH - 1; r++)
            for (int c = 1; c < BW - 1; c++) begin
                px = '0;
                for (int i = 0; i < 9; i++) px = {px[63:0], img_b[f][r - 1 + i / 3][c - 1 + i % 3]};
                qb.push_back({px, 8'(r), 8'(c), 1'(r == BH - 2 && c == BW - 2)});
            end
    endtask

    task automatic send_a(input logic [7:0] p);
        int n = 0;
        a.in_pix   = p;
        a.in_valid = 1'b1;
        @(negedge clk);
        while (!a.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $error("FAIL send_a in_ready observed=0 expected=1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        a.in_valid = 1'b0;
    endtask

    initial begin
        int base_w, idx, cyc;
        bit acc;
        win_t snap;
        a.in_pix = '0; a.in_valid = 1'b0; a.out_ready = 1'b1;
        b.in_pix = '0; b.in_valid = 1'b0; b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_a", a.out_valid, 1'b0);
        chk("rst_window_a", obs_a, '0);
        chk("rst_ready_a", a.in_ready, 1'b1);
        chk("rst_valid_b", b.out_valid, 1'b0);
        rst_n = 1'b1;

        // Frame 1: ramp, with a three-cycle stall on window (1,2)
        fill_a(8'h00, 1'b0);
        push_a(6);
        base_w = na_win;
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++) begin
                send_a(img_a[r][c]);
                if (r == 2 && c == 2) begin
                    chk("f1_first_valid", a.out_valid, 1'b1);
                    chk("f1_first_win", obs_a, {72'h000102101112202122, 8'd1, 8'd1, 1'b0});
                end
                if (r == 2 && c == 3) begin
                    a.in_pix = img_a[2][4]; a.in_valid = 1'b1; a.out_ready = 1'b0;
                    snap = obs_a;
                    chk("hold_center", {a.win_row, a.win_col}, {2'd1, 3'd2});
                    repeat (3) begin
                        @(negedge clk);
                        chk("hold_window", obs_a, snap);
                        chk("hold_valid", a.out_valid, 1'b1);
                        chk("hold_in_ready", a.in_ready, 1'b0);
                    end
                    @(posedge clk);
                    #1;
                    a.out_ready = 1'b1;
                end
                if (r == 3 && c < 2) chk("f1_row_start_quiet", a.out_valid, 1'b0);
                if (r == 3 && c == 4) begin
                    chk("f1_last_flag", a.win_last, 1'b1);
                    chk("f1_last_p22", a.P22, 8'h34);
                end
            end

        // Frame 2 back to back: no first-frame data may leak into its windows
        fill_a(8'h80, 1'b0);
        push_a(6);
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++) begin
                send_a(img_a[r][c]);
                if (r == 0 && c == 0) chk("f1_last_retired", a.out_valid, 1'b0);
                if (r == 2 && c == 2) begin
                    chk("f2_first_p00", a.P00, 8'h80);
                    chk("f2_first_p22", a.P22, 8'hA2);
                    chk("f2_first_center", {a.win_row, a.win_col}, {2'd1, 3'd1});
                end
            end
        repeat (3) @(posedge clk);
        #1;
        chk("f12_window_count", na_win - base_w, 12);
        chk("f12_last_count", na_last, 2);
        chk("f12_queue_empty", qa.size(), 0);
        chk("f12_idle_valid", a.out_valid, 1'b0);

        // Frame 3: random pixels, reset right after input (2,3)
        fill_a(8'h00, 1'b1);
        push_a(2);
        for (int i = 0; i < 2 * AW + 4; i++) send_a(img_a[i / AW][i % AW]);
        chk("f3_pending_valid", a.out_valid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", a.out_valid, 1'b0);
        chk("midrst_last", a.win_last, 1'b0);
        chk("midrst_window", obs_a, '0);
        chk("midrst_in_ready", a.in_ready, 1'b1);
        chk("midrst_queue_empty", qa.size(), 0);

        // Frame 4: fresh frame after reset must start at row 0 col 0
        fill_a(8'h40, 1'b0);
        push_a(6);
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++) begin
                send_a(img_a[r][c]);
                if (r == 2 && c == 2)
                    chk("f4_first_win", obs_a, {72'h404142505152606162, 8'd1, 8'd1, 1'b0});
            end
        repeat (3) @(posedge clk);
        #1;
        chk("f4_queue_empty", qa.size(), 0);

        // Randomized: 50% input bubbles, random backpressure, several back-to-back frames
        for (int f = 0; f < BF; f++) begin
            for (int r = 0; r < BH; r++)
                for (int c = 0; c < BW; c++) img_b[f][r][c] = 8'($urandom);
            push_b(f);
        end
        idx = 0;
        cyc = 0;
        while (idx < BF * BW * BH && cyc < 20000) begin
            b.in_valid  = 1'($urandom_range(0, 1));
            b.in_pix    = img_b[idx / (BW * BH)][(idx / BW) % BH][idx % BW];
            b.out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            acc = b.in_valid && b.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_all_accepted", idx, BF * BW * BH);
        chk("rand_window_count", nb_win, BF * (BW - 2) * (BH - 2));
        chk("rand_last_count", nb_last, BF);
        chk("rand_queue_empty", qb.size(), 0);
        chk("rand_idle_valid", b.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
